tx_serializer: RTL and testbench
================================

# tx_serializer

Parametrised transmit serializer for the digital block's TX path. Accepts parallel words through a valid/ready write port, queues them in a DEPTH-entry FIFO, and shifts them out one bit per enable strobe, MSB- or LSB-first. Consecutive words are sent back-to-back without gaps. It provides framing markers, fill level and underrun indication for the downstream line driver.

## Interface
- WIDTH, 8, word width in bits (≥2)
- DEPTH, 4, FIFO depth in words (power of 2, ≥2)
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush of FIFO and shifter
- din  in  WIDTH  write data
- din_valid  in  1  write request
- din_ready  out  1  FIFO not full (combinational from count)
- en  in  1  bit strobe; one bit is emitted per cycle with en=1
- dout  out  1  serial data (registered)
- dout_valid  out  1  dout carries a real bit this cycle (registered)
- frame_start  out  1  high with the first bit of each word (registered)
- frame_last  out  1  high with the last bit of each word (registered)
- underrun  out  1  one-cycle pulse: en=1 while shifter empty (registered)
- busy  out  1  shifter loaded or FIFO non-empty
- level  out  $clog2(DEPTH+1)  FIFO word count, excluding the shifter

## Operation
- Reset (rst=0): FIFO empty, shifter empty, bit counter 0. dout, dout_valid, frame_start, frame_last and underrun are 0. din_ready is 1, busy is 0, level is 0.
- Push: when din_valid && din_ready, din is written at the FIFO tail. When full, din_ready=0 and pushes are ignored, even if a pop occurs in the same cycle.
- Shifter states:
  - EMPTY: bit count 0.
  - LOADED: bit count 1..WIDTH.
- EMPTY → LOADED: FIFO non-empty, checked every cycle regardless of en. Pops the head, sets count=WIDTH, arms frame_start.
- Shifting in LOADED, on a cycle with en=1:
  - dout <= current output bit (buffer MSB if MSB_FIRST=1, else LSB); dout_valid <= 1.
  - Buffer shifts toward the output end with 0 fill; count decrements.
  - frame_start <= 1 on the first bit of the word; frame_last <= 1 when count==1.
- Back-to-back: when the last bit is sent and the FIFO is non-empty, the next word is popped in the same cycle (count=WIDTH). No idle bit is inserted.
- Last bit with FIFO empty: go to EMPTY.
- en=0: dout <= 0; dout_valid, frame_start and frame_last <= 0. Shifter state is held.
- en=1 in EMPTY: dout <= 0, dout_valid <= 0, underrun <= 1 for that cycle.
- clr=1: FIFO and shifter emptied; registered outputs <= 0. A push in the same cycle is discarded. clr takes priority over push, pop and shift.
- level changes:
  - +1 on a push alone.
  - −1 on a pop alone.
  - Unchanged when a push and a pop occur in the same cycle (allowed when not full).

## Timing
- Word accepted at edge N into an empty FIFO with an empty shifter:
  - Loaded into the shifter at edge N+1.
  - With en=1 from then on, bit 0 of the frame appears on dout after edge N+2.
  - Latency from accept to first bit is 2 cycles.
- With en held high, a word occupies exactly WIDTH consecutive dout_valid cycles. frame_start and frame_last coincide only if WIDTH=1, which is disallowed.
- With en held high and the FIFO kept non-empty, dout_valid stays continuously 1 across word boundaries.
- Asynchronous reset mid-word: in-flight and queued words are lost; outputs go to their reset values immediately.
- din_ready and level reflect state after the most recent edge. A push is visible in level one cycle after acceptance.

## Test plan
- **Basic MSB-first:** WIDTH=8, MSB_FIRST=1, push 0xA5, en=1 constantly.
  - dout sequence is 1,0,1,0,0,1,0,1 starting 2 cycles after accept.
  - frame_start on bit 1, frame_last on bit 8, then dout_valid=0 and underrun pulses each cycle.
- **LSB-first gapless:** MSB_FIRST=0, push 0x01 then 0x80, en=1.
  - 16 contiguous valid bits: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
  - No gap between words; two frame_start pulses, 8 cycles apart.
- **Full FIFO:** DEPTH=4, en=0, push 6 words.
  - 4 words plus 1 in the shifter are accepted (level=4); din_ready=0 afterwards and the 6th word is dropped.
  - With en=1, exactly 5 words are serialized in order.
- **en gating:** toggle en 1,0,1,0 during 0xF0.
  - dout=0 and dout_valid=0 on en=0 cycles; the bit sequence resumes without loss.
- **clr mid-word:** clr after 3 bits of 0xFF with 2 words queued.
  - Next cycle: level=0, busy=0, dout_valid=0; no further bits.
- **Async reset:** rst low mid-stream.
  - All outputs 0 and din_ready=1 immediately; a fresh push afterwards serializes correctly.

Source files
------------

// File: rtl/tx_serializer.sv
// tx_serializer
// Accepts parallel words on a valid/ready write port, queues them in a
// DEPTH-entry FIFO and shifts them out one bit per enable strobe. Words are
// sent back-to-back, with no gap, for as long as the FIFO stays non-empty.
//
// Ports:
//   clk, rst (async, active-low), clr (sync flush of FIFO and shifter)
//   din/din_valid/din_ready : write port
//   en                      : bit strobe, one bit out per cycle with en=1
//   dout/dout_valid         : registered serial data and qualifier
//   frame_start/frame_last  : registered markers on first/last bit of a word
//   underrun                : registered pulse, en=1 while the shifter is empty
//   busy                    : shifter loaded or FIFO non-empty
//   level                   : FIFO word count, not counting the shifter
//   dbg_state               : shifter FSM state (0=EMPTY, 1=LOADED)
//
// Handshake: a word is accepted on a rising edge where din_valid && din_ready
// and clr is low. din_ready depends only on the FIFO count, never on
// din_valid. When the FIFO is full a push is refused, even if a pop happens
// in the same cycle.
module tx_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic                         en,
  output logic                         dout,
  output logic                         dout_valid,
  output logic                         frame_start,
  output logic                         frame_last,
  output logic                         underrun,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_LOADED = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic [WIDTH-1:0] r_buf;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_first;
  logic             w_full, w_fifo_ne, w_push, w_pop, w_shift, w_last_bit;

  assign w_full     = (r_count == LW'(DEPTH));
  assign w_fifo_ne  = (r_count != '0);
  assign din_ready  = !w_full;
  assign w_push     = din_valid && !w_full && !clr;
  assign w_last_bit = (r_bit_cnt == CW'(1));
  assign busy       = (r_state == ST_LOADED) || w_fifo_ne;
  assign level      = r_count;
  assign dbg_state  = r_state;

  // Next state: loading from the FIFO does not wait for en, and the final
  // bit of a word reloads immediately so consecutive words are gapless.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    if (clr) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fifo_ne) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (en) begin
            w_shift = 1'b1;
            if (w_last_bit) begin
              if (w_fifo_ne) w_pop = 1'b1;
              else           w_state_nxt = ST_EMPTY;
            end
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // FIFO storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Shifter and registered outputs. A pop in the same cycle as the last
  // shift overrides the shift's buffer/count update (later assignment wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf       <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      underrun    <= 1'b0;
    end else if (clr) begin
      r_buf       <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      underrun    <= en && (r_state == ST_EMPTY);
      if (w_shift) begin
        dout_valid  <= 1'b1;
        frame_start <= r_first;
        frame_last  <= w_last_bit;
        r_first     <= 1'b0;
        r_bit_cnt   <= r_bit_cnt - CW'(1);
        if (MSB_FIRST) begin
          dout  <= r_buf[WIDTH-1];
          r_buf <= {r_buf[WIDTH-2:0], 1'b0};
        end else begin
          dout  <= r_buf[0];
          r_buf <= {1'b0, r_buf[WIDTH-1:1]};
        end
      end
      if (w_pop) begin
        r_buf     <= r_mem[r_rd_ptr];
        r_bit_cnt <= CW'(WIDTH);
        r_first   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
module tb_tx_serializer;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] din;
  logic       din_valid;
  logic       en;

  logic       m_ready, m_dout, m_valid, m_fs, m_fl, m_ur, m_busy, m_st;
  logic [2:0] m_level;
  logic       l_ready, l_dout, l_valid, l_fs, l_fl, l_ur, l_busy, l_st;
  logic [2:0] l_level;

  int n_tests = 0;
  int n_fail  = 0;

  tx_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .en(en), .dout(m_dout), .dout_valid(m_valid),
    .frame_start(m_fs), .frame_last(m_fl), .underrun(m_ur), .busy(m_busy),
    .level(m_level), .dbg_state(m_st)
  );

  tx_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .en(en), .dout(l_dout), .dout_valid(l_valid),
    .frame_start(l_fs), .frame_last(l_fl), .underrun(l_ur), .busy(l_busy),
    .level(l_level), .dbg_state(l_st)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    en        = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; din = '0; din_valid = 1'b0; en = 1'b0;
    tick(); tick();
    n_tests++;
    if ({m_dout, m_valid, m_fs, m_fl, m_ur, m_busy, m_st, m_level, m_ready} !== 11'b0000000_000_1) begin
      n_fail++;
      $display("FAIL reset_msb: got %b want 0000000_000_1",
               {m_dout, m_valid, m_fs, m_fl, m_ur, m_busy, m_st, m_level, m_ready});
    end
    n_tests++;
    if ({l_dout, l_valid, l_fs, l_fl, l_ur, l_busy, l_st, l_level, l_ready} !== 11'b0000000_000_1) begin
      n_fail++;
      $display("FAIL reset_lsb: got %b want 0000000_000_1",
               {l_dout, l_valid, l_fs, l_fl, l_ur, l_busy, l_st, l_level, l_ready});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_msb();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    din = 8'hA5; din_valid = 1'b1; en = 1'b1;
    tick();                       // accepted
    din_valid = 1'b0;
    n_tests++;
    if (m_level !== 3'd1) begin
      n_fail++; $display("FAIL basic_level_after_push: got %0d want 1", m_level);
    end
    tick();                       // loaded into shifter
    n_tests++;
    if (m_valid !== 1'b0 || m_ur !== 1'b1 || m_st !== 1'b1 || m_level !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_load: valid=%b ur=%b st=%b level=%0d want 0 1 1 0", m_valid, m_ur, m_st, m_level);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (m_dout !== exp_bits[7-i] || m_valid !== 1'b1 || m_fs !== (i == 0) || m_fl !== (i == 7)) begin
        n_fail++;
        $display("FAIL basic_bit%0d: dout=%b valid=%b fs=%b fl=%b want %b 1 %b %b",
                 i, m_dout, m_valid, m_fs, m_fl, exp_bits[7-i], (i == 0), (i == 7));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (m_valid !== 1'b0 || m_ur !== 1'b1 || m_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_underrun%0d: valid=%b ur=%b busy=%b want 0 1 0", i, m_valid, m_ur, m_busy);
      end
    end
    idle(2);
  endtask

  task automatic test_lsb_gapless();
    logic [15:0] exp_bits;
    exp_bits = 16'b1000_0000_0000_0001;   // bit i = i-th emitted bit
    din = 8'h01; din_valid = 1'b1; en = 1'b1;
    tick();
    din = 8'h80;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_tests++;
      if (l_dout !== exp_bits[i] || l_valid !== 1'b1 || l_fs !== (i == 0 || i == 8) ||
          l_fl !== (i == 7 || i == 15)) begin
        n_fail++;
        $display("FAIL lsb_bit%0d: dout=%b valid=%b fs=%b fl=%b want %b 1 %b %b",
                 i, l_dout, l_valid, l_fs, l_fl, exp_bits[i], (i == 0 || i == 8), (i == 7 || i == 15));
      end
    end
    tick();
    n_tests++;
    if (l_valid !== 1'b0 || l_ur !== 1'b1) begin
      n_fail++; $display("FAIL lsb_end: valid=%b ur=%b want 0 1", l_valid, l_ur);
    end
    idle(2);
  endtask

  task automatic test_full_fifo();
    logic [7:0] words [6];
    logic [2:0] exp_lvl [6];
    logic       exp_rdy [6];
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = words[i]; din_valid = 1'b1;
      tick();
      n_tests++;
      if (m_level !== exp_lvl[i] || m_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL full_push%0d: level=%0d ready=%b want %0d %b", i, m_level, m_ready, exp_lvl[i], exp_rdy[i]);
      end
    end
    din_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (m_dout !== words[i/8][7-(i%8)] || m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_bit%0d: dout=%b valid=%b want %b 1", i, m_dout, m_valid, words[i/8][7-(i%8)]);
      end
    end
    tick();
    n_tests++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_level !== 3'd0) begin
      n_fail++; $display("FAIL full_end: valid=%b busy=%b level=%0d want 0 0 0", m_valid, m_busy, m_level);
    end
    idle(2);
  endtask

  task automatic test_en_gating();
    logic [7:0] exp_bits;
    int         b;
    exp_bits = 8'hF0;
    b = 0;
    en = 1'b0; din = 8'hF0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      tick();
      n_tests++;
      if (en) begin
        if (m_dout !== exp_bits[7-b] || m_valid !== 1'b1 || m_fs !== (b == 0) || m_fl !== (b == 7)) begin
          n_fail++;
          $display("FAIL gate_bit%0d: dout=%b valid=%b fs=%b fl=%b want %b 1 %b %b",
                   b, m_dout, m_valid, m_fs, m_fl, exp_bits[7-b], (b == 0), (b == 7));
        end
        b++;
      end else begin
        if (m_dout !== 1'b0 || m_valid !== 1'b0 || m_fs !== 1'b0 || m_fl !== 1'b0 || m_ur !== 1'b0) begin
          n_fail++;
          $display("FAIL gate_off%0d: dout=%b valid=%b fs=%b fl=%b ur=%b want 0 0 0 0 0",
                   i, m_dout, m_valid, m_fs, m_fl, m_ur);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_clr();
    logic [7:0] words [3];
    words = '{8'hFF, 8'h12, 8'h34};
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = words[i]; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    n_tests++;
    if (m_level !== 3'd2 || m_busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_pre: level=%0d busy=%b want 2 1", m_level, m_busy);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (m_dout !== 1'b1 || m_valid !== 1'b1) begin
        n_fail++; $display("FAIL clr_bit%0d: dout=%b valid=%b want 1 1", i, m_dout, m_valid);
      end
    end
    clr = 1'b1; din = 8'h55; din_valid = 1'b1;   // this push must be discarded
    tick();
    clr = 1'b0; din_valid = 1'b0;
    n_tests++;
    if (m_level !== 3'd0 || m_busy !== 1'b0 || m_valid !== 1'b0 || m_dout !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after: level=%0d busy=%b valid=%b dout=%b want 0 0 0 0", m_level, m_busy, m_valid, m_dout);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (m_valid !== 1'b0 || m_ur !== 1'b1 || m_level !== 3'd0) begin
        n_fail++; $display("FAIL clr_idle%0d: valid=%b ur=%b level=%0d want 0 1 0", i, m_valid, m_ur, m_level);
      end
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_bits;
    exp_bits = 8'h3C;
    din = 8'hC3; din_valid = 1'b1; en = 1'b1;
    tick();
    din = 8'h99;                                  // queue a second word too
    tick();
    din_valid = 1'b0;
    tick(); tick();                               // two bits out
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({m_dout, m_valid, m_fs, m_fl, m_ur, m_busy, m_level, m_ready} !== 10'b000000_000_1) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 000000_000_1",
               {m_dout, m_valid, m_fs, m_fl, m_ur, m_busy, m_level, m_ready});
    end
    rst = 1'b1;
    din = 8'h3C; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (m_dout !== exp_bits[7-i] || m_valid !== 1'b1 || m_fs !== (i == 0)) begin
        n_fail++;
        $display("FAIL async_bit%0d: dout=%b valid=%b fs=%b want %b 1 %b",
                 i, m_dout, m_valid, m_fs, exp_bits[7-i], (i == 0));
      end
    end
    tick();
    n_tests++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      n_fail++; $display("FAIL async_end: valid=%b busy=%b want 0 0", m_valid, m_busy);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_lsb_gapless();
    test_full_fifo();
    test_en_gating();
    test_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
